shift_add_multiplier: RTL
=========================

# shift_add_multiplier

Sequential unsigned shift-and-add multiplier. It sits directly downstream of the input two's-complement magnitude stage and consumes the 12-bit unsigned magnitudes that stage produces. It returns the full-width product after a fixed number of cycles, using a start/busy/done handshake. An optional sign-restore path re-applies the operand signs, so the block can also deliver a signed product.

## Interface
- WIDTH, 12, operand width in bits; product is 2*WIDTH bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clock clk.
- start  input  1  request a multiply; sampled only in IDLE.
- a_in  input  WIDTH  unsigned multiplicand (magnitude).
- b_in  input  WIDTH  unsigned multiplier (magnitude).
- sign_a  input  1  sign of the original a operand; used only with SIGN_RESTORE_EN.
- sign_b  input  1  sign of the original b operand; used only with SIGN_RESTORE_EN.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  registered result; holds until the next completion.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - On start=1, latch a_in zero-extended into the 2*WIDTH multiplicand register.
  - Latch b_in into the WIDTH multiplier shift register.
  - Clear the accumulator; clear the iteration counter (clog2(WIDTH+1) bits).
  - Latch sign_a^sign_b into the neg flag.
  - Go to RUN.
- RUN, once per cycle:
  - If multiplier[0]=1, accumulator += multiplicand (2*WIDTH-bit add, no overflow possible).
  - multiplicand <<= 1; multiplier >>= 1; counter += 1.
  - When the iteration that brings the counter to WIDTH completes, load product from the final accumulator value (including that iteration's add) and go to DONE.
- DONE: done=1 for this single cycle, then go to IDLE unconditionally.
- Arithmetic:
  - All magnitudes are unsigned; the maximum product is (2^WIDTH-1)^2, which fits in 2*WIDTH bits.
  - An input of 2^(WIDTH-1) (from the most-negative signed value) is a legal magnitude.
- start while in RUN or DONE is ignored; there is no queueing. The requester must wait for done before issuing a new start.
- start held high continuously begins a new operation on every return to IDLE.
- Operand inputs need only be valid in the cycle start is sampled.
- reset mid-operation:
  - Aborts immediately: state IDLE, busy=0, done=0, product=0.
  - Accumulator, multiplicand, multiplier, counter and neg are cleared; no partial result is ever published.

## Timing
- Reset values: busy=0, done=0, product=0.
- Let start be sampled at rising edge E0. Then:
  - busy=1 from after E0 through edge E(WIDTH).
  - product updates at edge E(WIDTH).
  - done=1 for the cycle between E(WIDTH) and E(WIDTH+1).
  - Total latency from start to done is WIDTH+1 edges: 13 for WIDTH=12.
- Earliest next accepted start is at edge E(WIDTH+2). Throughput is one product per WIDTH+2 cycles.
- busy and done are never high simultaneously.
- product is stable whenever done=0, except at the update edge.

## Configuration
- Macro SIGN_RESTORE_EN.
- Defined:
  - At load into product, if neg=1 then product = ~acc + 1 (2*WIDTH-bit two's complement), otherwise product = acc.
  - The result is a signed 2*WIDTH-bit value. This is valid for magnitudes up to 2^(WIDTH-1), i.e. inputs produced from signed WIDTH-bit operands.
- Undefined:
  - sign_a and sign_b are ignored and the neg flag is not implemented.
  - product is always the unsigned magnitude product.
- Latency and handshake are identical in both builds.

## Test plan
- Basic multiply: reset, then start with a_in=3, b_in=5 -> done pulses exactly 13 cycles after start is sampled; product=15 (0x00000F); busy high for 12 cycles.
- Maximum operands: a_in=4095, b_in=4095 -> product=0xFFE001. Then a_in=2048, b_in=2048 -> product=0x400000.
- Zero operand: a_in=0, b_in=1234 -> product=0. Then a_in=1234, b_in=0 -> product=0, each with full 13-cycle latency.
- Ignored start: issue a_in=7, b_in=9; pulse start with a_in=100, b_in=100 during RUN and during DONE -> product=63, a single done pulse, and no second operation begins.
- Reset mid-operation: start a_in=4095, b_in=4095; assert reset at cycle 6 of RUN -> next cycle busy=0, done=0, product=0. No done occurs; a subsequent 2*3 yields 6.
- SIGN_RESTORE_EN build:
  - a_in=7, sign_a=1, b_in=9, sign_b=0 -> product=0xFFFFC1 (-63).
  - Same operands with sign_a=1, sign_b=1 -> product=0x00003F (63).
  - a_in=2048, sign_a=1, b_in=1, sign_b=0 -> product=0xFFF800.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with start/busy/done handshake.
// Optional sign restore of the product is enabled by defining SIGN_RESTORE_EN.
module shift_add_multiplier #(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 sign_a,
    input  logic                 sign_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [PW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;
    logic [PW-1:0]      acc;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      acc_sum;
    logic               last_iter;
    logic               neg;

`ifdef SIGN_RESTORE_EN
    // Two's-complement the magnitude when exactly one operand was negative.
    function automatic logic [PW-1:0] restore_sign(input logic [PW-1:0] mag,
                                                   input logic          neg_f);
        restore_sign = neg_f ? (~mag + PW'(1)) : mag;
    endfunction
`else
    function automatic logic [PW-1:0] restore_sign(input logic [PW-1:0] mag,
                                                   input logic          neg_f);
        restore_sign = neg_f ? mag : mag;
    endfunction

    logic unused_signs;
    assign unused_signs = sign_a ^ sign_b;
`endif

    // Partial-product add for the current iteration; the final one feeds product directly.
    assign acc_sum   = acc + (mplier[0] ? mcand : '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= PW'(a_in);
                        mplier <= b_in;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        product <= restore_sign(acc_sum, neg);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SIGN_RESTORE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            neg <= 1'b0;
        end else if (state == IDLE && start) begin
            neg <= sign_a ^ sign_b;
        end
    end
`else
    assign neg = 1'b0;
`endif

endmodule
